// File: rtl/spram_be_ctrl_if.sv
// Request/response bundle for the byte-enabled single-port RAM controller.
// The master issues requests; the slave (the controller) returns read data.
interface spram_be_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 64
) ();
  logic                  me;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   ben;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  rerr;
  logic                  ready;

  modport master (
    output me, wen, addr, wdata, ben,
    input  rdata, rvalid, rerr, ready
  );

  modport slave (
    input  me, wen, addr, wdata, ben,
    output rdata, rvalid, rerr, ready
  );
endinterface

// File: rtl/spram_be_ctrl.sv
// Single-port RAM with byte write enables, self-clearing after reset and a
// fully pipelined read path of RD_LAT cycles with out-of-range error flag.
module spram_be_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input logic            clk,
  input logic            reset,
  spram_be_ctrl_if.slave bus
);
  localparam int unsigned          BE_W     = DATA_W / 8;
  localparam int unsigned          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]      DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;
  logic             ready_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              clr_we;
  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  // Clear and user writes share the single write port; clear owns it in CLEAR.
  always_comb begin
    in_range = ({1'b0, bus.addr} < DEPTH_A);
    idx      = bus.addr[IDX_W-1:0];
    clr_we   = reset && (state == CLEAR);
    wr_acc   = reset && (state == RUN) && bus.me && bus.wen && in_range;
    rd_acc   = reset && (state == RUN) && bus.me && !bus.wen;
    mem_we   = clr_we || wr_acc;
    wr_idx   = clr_we ? clr_cnt : idx;
    wr_data  = clr_we ? '0 : bus.wdata;
    wr_be    = clr_we ? '1 : bus.ben;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else if (state == CLEAR) begin
      if (clr_cnt == LAST_IDX) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  logic              pv [RD_LAT];
  logic              pe [RD_LAT];
  logic [DATA_W-1:0] pd [RD_LAT];

  // Data stages only load behind a valid, so the last stage holds the most
  // recent returned word while no read is emerging.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= rd_acc;
      pe[0] <= rd_acc && !in_range;
      if (rd_acc) pd[0] <= in_range ? mem[idx] : '0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        if (pv[i-1]) pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.rdata  = pd[RD_LAT-1];
  assign bus.rvalid = pv[RD_LAT-1];
  assign bus.rerr   = pe[RD_LAT-1];
  assign bus.ready  = ready_q;
endmodule

// File: tb/tb_spram_be_ctrl.sv
// Scoreboard bench for spram_be_ctrl: DEPTH=16, ADDR_W=8, DATA_W=64, RD_LAT=2.
module tb_spram_be_ctrl;
  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 64;
  localparam int unsigned DEP = 16;
  localparam int unsigned LAT = 2;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  spram_be_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  spram_be_ctrl #(
    .ADDR_W(AW),
    .DEPTH (DEP),
    .DATA_W(DW),
    .RD_LAT(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] model [DEP];
  exp_t          sb [$];
  logic [DW-1:0] last_rdata = '0;
  logic          rst_seen   = 1'b0;
  logic          mon_exp_v;
  exp_t          mon_e;

  // Every cycle: rvalid must match the scoreboard's due cycle exactly.
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (!rst_seen) last_rdata = '0;
      mon_exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      vectors++;
      if (bus.rvalid !== mon_exp_v) begin
        miscompares++;
        $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, bus.rvalid, mon_exp_v);
      end
      if (mon_exp_v) begin
        mon_e = sb.pop_front();
        vectors++;
        if (bus.rdata !== mon_e.data) begin
          miscompares++;
          $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, bus.rdata, mon_e.data);
        end
        vectors++;
        if (bus.rerr !== mon_e.err) begin
          miscompares++;
          $display("FAIL rerr cyc=%0d got=%b exp=%b", cyc, bus.rerr, mon_e.err);
        end
        last_rdata = mon_e.data;
      end else begin
        vectors++;
        if (bus.rerr !== 1'b0) begin
          miscompares++;
          $display("FAIL rerr_idle cyc=%0d got=%b exp=0", cyc, bus.rerr);
        end
        vectors++;
        if (bus.rdata !== last_rdata) begin
          miscompares++;
          $display("FAIL rdata_hold cyc=%0d got=%h exp=%h", cyc, bus.rdata, last_rdata);
        end
      end
    end
    rst_seen = reset;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.me  = 1'b0;
    bus.wen = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] be);
    bus.me = 1'b1; bus.wen = 1'b1; bus.addr = a; bus.wdata = d; bus.ben = be;
    if (a < DEP) begin
      for (int i = 0; i < 8; i++) if (be[i]) model[a[3:0]][8*i +: 8] = d[8*i +: 8];
    end
    tick();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    exp_t e;
    bus.me = 1'b1; bus.wen = 1'b0; bus.addr = a;
    bus.wdata = {$urandom, $urandom}; bus.ben = 8'($urandom);
    e.due  = cyc + LAT;
    e.err  = (a >= DEP);
    e.data = (a < DEP) ? model[a[3:0]] : '0;
    sb.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; idle(); bus.addr = '0; bus.wdata = '0; bus.ben = '0;
    for (int i = 0; i < DEP; i++) model[i] = '0;
    repeat (3) tick();
    vectors++;
    if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_state got ready=%b rvalid=%b rdata=%h exp 0/0/0", bus.ready, bus.rvalid, bus.rdata);
    end
    // Garbage write requests during clear must be ignored.
    bus.me = 1'b1; bus.wen = 1'b1; bus.ben = '1; bus.wdata = '1;
    reset = 1'b1;
    for (int k = 1; k <= DEP; k++) begin
      bus.addr = AW'(k - 1);
      tick();
      vectors++;
      if (bus.ready !== (k == DEP)) begin
        miscompares++;
        $display("FAIL ready_rise edge=%0d got=%b exp=%b", k, bus.ready, (k == DEP));
      end
    end
    idle();
  endtask

  task automatic test_clear();
    for (int a = 0; a < DEP; a++) do_read(AW'(a));
    idle();
    repeat (LAT + 2) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL clear_drain pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_byte_mask();
    do_write(8'd3, 64'h1122334455667788, 8'hFF);
    do_write(8'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    do_write(8'd3, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    do_read(8'd3);
    idle();
    repeat (LAT + 1) tick();
    vectors++;
    if (bus.rdata !== 64'h11223344AAAAAAAA) begin
      miscompares++;
      $display("FAIL byte_mask got=%h exp=%h", bus.rdata, 64'h11223344AAAAAAAA);
    end
  endtask

  task automatic test_latency();
    logic exp_v;
    for (int i = 0; i < 4; i++) do_write(AW'(i), 64'hC0DE_0000_0000_0000 | DW'(i * 17 + 1), 8'hFF);
    do_read(8'd0);
    vectors++;
    if (bus.rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_early got=%b exp=0", bus.rvalid);
    end
    idle();
    tick();
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== model[0]) begin
      miscompares++;
      $display("FAIL lat_on got rvalid=%b rdata=%h exp 1/%h", bus.rvalid, bus.rdata, model[0]);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) do_read(AW'(i));
      else begin idle(); tick(); end
      exp_v = (i >= 1 && i <= 4);
      vectors++;
      if (bus.rvalid !== exp_v || (exp_v && bus.rdata !== model[i-1])) begin
        miscompares++;
        $display("FAIL b2b step=%0d got rvalid=%b rdata=%h exp rvalid=%b", i, bus.rvalid, bus.rdata, exp_v);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(8'd5, 64'hDEAD, 8'hFF);
    do_read(8'd5);
    idle();
    tick();
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 64'hDEAD) begin
      miscompares++;
      $display("FAIL wr_then_rd got rvalid=%b rdata=%h exp 1/000000000000dead", bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_out_of_range();
    do_write(8'd4, 64'h0404040404040404, 8'hFF);
    do_write(8'd20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    do_read(8'd20);
    do_read(8'd4);
    vectors++;
    if (bus.rvalid !== 1'b1 || bus.rerr !== 1'b1 || bus.rdata !== '0) begin
      miscompares++;
      $display("FAIL oob_read got rvalid=%b rerr=%b rdata=%h exp 1/1/0", bus.rvalid, bus.rerr, bus.rdata);
    end
    idle();
    tick();
    vectors++;
    if (bus.rerr !== 1'b0 || bus.rdata !== 64'h0404040404040404) begin
      miscompares++;
      $display("FAIL oob_no_alias got rerr=%b rdata=%h exp 0/0404040404040404", bus.rerr, bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    do_write(8'd3, 64'h3333333333333333, 8'hFF);
    do_read(8'd3);
    reset = 1'b0;
    sb.delete();
    idle();
    tick();
    vectors++;
    if (bus.rvalid !== 1'b0 || bus.ready !== 1'b0 || bus.rdata !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got rvalid=%b ready=%b rdata=%h exp 0/0/0", bus.rvalid, bus.ready, bus.rdata);
    end
    for (int i = 0; i < DEP; i++) model[i] = '0;
    reset = 1'b1;
    for (int k = 1; k <= DEP; k++) begin
      tick();
      vectors++;
      if (bus.ready !== (k == DEP) || bus.rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL reclear edge=%0d got ready=%b rvalid=%b exp ready=%b rvalid=0", k, bus.ready, bus.rvalid, (k == DEP));
      end
    end
    do_read(8'd3);
    idle();
    repeat (LAT + 2) tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain pending=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_byte_mask();
    test_latency();
    test_write_read();
    test_out_of_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spram_be_ctrl.md
SPRAM_BE_CTRL -- requirements
Module: spram_be_ctrl

Interface
Parameters:
REQ-001 SHALL provide parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL provide parameter DEPTH, default 1024, number of words; legal range 2..2**ADDR_W.
REQ-003 SHALL provide parameter DATA_W, default 64, word width; multiple of 8.
REQ-004 SHALL provide parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.

Ports:
REQ-005 SHALL provide port clk, input, 1, single clock; all logic on posedge.
REQ-006 SHALL provide port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL provide port me, input, 1, memory enable; a request exists only when me=1.
REQ-008 SHALL provide port wen, input, 1, 1=write, 0=read; ignored when me=0.
REQ-009 SHALL provide port addr, input, ADDR_W, word address.
REQ-010 SHALL provide port wdata, input, DATA_W, write data.
REQ-011 SHALL provide port ben, input, DATA_W/8, byte write enables; bit i covers wdata[8i+7:8i].
REQ-012 SHALL provide port rdata, output, DATA_W, read data.
REQ-013 SHALL provide port rvalid, output, 1, one-cycle pulse marking rdata valid.
REQ-014 SHALL provide port rerr, output, 1, pulses with rvalid when the read address was out of range.
REQ-015 SHALL provide port ready, output, 1, high when requests are accepted.

Function
REQ-016 SHALL implement a two-state FSM, CLEAR and RUN; reset forces CLEAR with clear counter 0.
REQ-017 In CLEAR, SHALL write 0 to word k on the k-th posedge after reset deasserts (k=0..DEPTH-1), ignoring me, wen, addr, wdata and ben.
REQ-018 SHALL set ready=1 and enter RUN on the edge that clears word DEPTH-1.
REQ-019 In RUN, SHALL accept one request per cycle; no backpressure.
REQ-020 A write with me=1, wen=1 and addr<DEPTH SHALL update only the bytes with ben[i]=1 at that edge; ben=0 leaves the word unchanged.
REQ-021 A write with addr>=DEPTH SHALL be dropped with no side effects and no rerr.
REQ-022 A read accepted at edge N SHALL present data on rdata with rvalid=1 for exactly the cycle following edge N+RD_LAT-1, i.e. RD_LAT cycles after acceptance.
REQ-023 Reads SHALL be fully pipelined; back-to-back reads produce back-to-back rvalid pulses in order.
REQ-024 A read SHALL return the contents after every write accepted at an earlier edge; write then read of the same address on consecutive cycles returns the new data.
REQ-025 A read with addr>=DEPTH SHALL return rdata=0 with rvalid=1 and rerr=1 at the normal latency.
REQ-026 rdata SHALL hold its last valid value while rvalid=0.
REQ-027 rerr SHALL be 0 whenever rvalid=0.

Reset
REQ-028 While reset=0 at an edge, SHALL set rdata=0, rvalid=0, rerr=0 and ready=0.
REQ-029 While reset=0 at an edge, SHALL flush all in-flight reads so that no rvalid appears for them afterwards.
REQ-030 Reset asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from word 0.
REQ-031 Memory contents SHALL be defined only through CLEAR; no reset of array cells beyond CLEAR.

Verification
REQ-032 Bench SHALL cover the clear sequence (DEPTH=16): release reset -> ready rises on the 16th edge; read of every address returns 0 with rerr=0.
REQ-033 Bench SHALL cover byte mask: write addr 3 with 0x1122334455667788 and ben=0xFF, then write 0xAAAAAAAAAAAAAAAA with ben=0x0F -> read addr 3 returns 0x11223344AAAAAAAA.
REQ-034 Bench SHALL cover latency (RD_LAT=2): read at edge N -> rvalid high only after edge N+1; four back-to-back reads of addr 0..3 give four consecutive rvalid pulses in order.
REQ-035 Bench SHALL cover write-then-read: write 0xDEAD to addr 5 at edge N and read addr 5 at edge N+1 -> returns 0xDEAD.
REQ-036 Bench SHALL cover out of range (DEPTH=16, ADDR_W=8): write addr 20, then read addr 20 -> rdata=0, rvalid=1, rerr=1; addr 4 is unchanged.
REQ-037 Bench SHALL cover reset mid-operation: issue a read, then assert reset one cycle later -> no rvalid appears, ready=0, and CLEAR reruns for 16 cycles.
